wca_rssi_scheduler: RTL and testbench

Time-multiplexes one RSSI measurement engine across NCH ADC channels. A round-robin FSM selects each enabled channel in turn. It discards a settle window of samples, then integrates |adc| over a power-of-two dwell and publishes an 8-bit block-average RSSI per channel. It sits between the ADC sample bus and the host register bank, and runs either single-shot (start pulse) or continuous (enable).

---
 rtl/wca_rssi_pkg.sv | 34 +++
 rtl/wca_rssi_integrator.sv | 65 ++++++
 rtl/wca_rssi_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_wca_rssi_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wca_rssi_pkg.sv
// Shared types and helpers for the RSSI scheduler slice.
package wca_rssi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_PUBLISH
   } state_e;

   localparam int unsigned ADC_W  = 12;
   localparam int unsigned ABS_W  = 11;
   localparam int unsigned RSSI_W = 8;
   localparam int unsigned ACC_W  = 26;

   // Next set bit strictly above cur, wrapping; returns cur when mask is empty.
   // Mask is zero-extended to 16 so the wrap falls through unused upper bits.
   function automatic logic [3:0] next_chan(input logic [15:0] mask, input logic [3:0] cur);
      logic [3:0] res;
      logic [3:0] idx;
      logic       found;
      res   = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= 16; i++) begin
         idx = cur + 4'(i);
         if (!found && mask[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/wca_rssi_integrator.sv
// Magnitude accumulator for one dwell: |adc| sum, block average and optional
// peak tracker (WCA_RSSI_PEAK_EN). avg/peak reflect this cycle's sample so the
// caller can register them on the final dwell strobe.
module wca_rssi_integrator
   import wca_rssi_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              acc_en,
   input  logic [3:0]        dwell_log2,
   input  logic [ADC_W-1:0]  sample,
   output logic [RSSI_W-1:0] avg,
   output logic [RSSI_W-1:0] peak
);

   logic [ABS_W-1:0] mag;
   logic [ACC_W-1:0] acc_q, acc_d;

   // Ones'-complement magnitude of the selected sample.
   always_comb begin
      mag = sample[ADC_W-1] ? ~sample[ABS_W-1:0] : sample[ABS_W-1:0];
   end

   // Accumulate on enable, clear between channels; average = (acc >> dwell)[10:3].
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (acc_en) begin
         acc_d = acc_q + ACC_W'(mag);
      end
      avg = RSSI_W'(acc_d >> ({1'b0, dwell_log2} + 5'd3));
   end

   // Accumulator register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

`ifdef WCA_RSSI_PEAK_EN
   logic [RSSI_W-1:0] peak_q, peak_d;

   // Running maximum of mag[10:3], cleared together with the accumulator.
   always_comb begin
      peak_d = peak_q;
      if (clr) begin
         peak_d = '0;
      end else if (acc_en && (mag[ABS_W-1:3] > peak_q)) begin
         peak_d = mag[ABS_W-1:3];
      end
      peak = peak_d;
   end

   // Peak register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) peak_q <= '0;
      else       peak_q <= peak_d;
   end
`else
   assign peak = '0;
`endif

endmodule

// File: rtl/wca_rssi_scheduler.sv
// Round-robin RSSI scheduler: shares one integrator across NCH ADC channels,
// single-shot (start) or continuous (enable). Optional peak output under
// WCA_RSSI_PEAK_EN; rssi_peak reads 0 otherwise.
module wca_rssi_scheduler
   import wca_rssi_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CHW = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                start,
   input  logic [NCH-1:0]      rssi_mask,
   input  logic [7:0]          settle,
   input  logic [3:0]          dwell_log2,
   input  logic                strobe,
   input  logic [NCH*12-1:0]   adc,
   output logic [CHW-1:0]      sel,
   output logic                busy,
   output logic                rssi_vld,
   output logic [CHW-1:0]      rssi_ch,
   output logic [7:0]          rssi_val,
   output logic [NCH*8-1:0]    rssi_bank,
   output logic                done,
   output logic [7:0]          rssi_peak
);

   state_e              state_q, state_d;
   logic [NCH-1:0]      mask_q, mask_d;
   logic [7:0]          settle_q, settle_d;
   logic [3:0]          dwell_q, dwell_d;
   logic [CHW-1:0]      sel_q, sel_d;
   logic                cont_q, cont_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                vld_q, vld_d;
   logic [CHW-1:0]      ch_q, ch_d;
   logic [RSSI_W-1:0]   val_q, val_d;
   logic [NCH*8-1:0]    bank_q, bank_d;
   logic                done_q, done_d;
   logic [RSSI_W-1:0]   peak_q, peak_d;

   logic                clr, acc_en;
   logic [ADC_W-1:0]    sample;
   logic [RSSI_W-1:0]   avg, peak;
   logic [15:0]         cur_mask, new_mask;
   logic [CHW-1:0]      nxt_sel, first_sel;

   // Channel mux and round-robin candidates.
   always_comb begin
      sample   = adc[int'(sel_q)*ADC_W +: ADC_W];
      cur_mask = '0;
      cur_mask[NCH-1:0] = mask_q;
      new_mask = '0;
      new_mask[NCH-1:0] = rssi_mask;
      nxt_sel   = CHW'(next_chan(cur_mask, 4'(sel_q)));
      first_sel = CHW'(next_chan(new_mask, 4'(NCH - 1)));
   end

   wca_rssi_integrator u_integ (
      .clock      (clock),
      .reset      (reset),
      .clr        (clr),
      .acc_en     (acc_en),
      .dwell_log2 (dwell_q),
      .sample     (sample),
      .avg        (avg),
      .peak       (peak)
   );

   // Next-state and result logic. Results latch on the final dwell strobe so
   // rssi_vld is high during the PUBLISH cycle and done follows one cycle later.
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      settle_d = settle_q;
      dwell_d  = dwell_q;
      sel_d    = sel_q;
      cont_d   = cont_q;
      cnt_d    = cnt_q;
      vld_d    = 1'b0;
      ch_d     = ch_q;
      val_d    = val_q;
      bank_d   = bank_q;
      done_d   = 1'b0;
      peak_d   = peak_q;
      clr      = 1'b0;
      acc_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clr   = 1'b1;
            cnt_d = '0;
            if ((enable || start) && (rssi_mask != '0)) begin
               mask_d   = rssi_mask;
               settle_d = settle;
               dwell_d  = dwell_log2;
               sel_d    = first_sel;
               cont_d   = enable;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q == 8'd0) begin
               cnt_d   = '0;
               state_d = ST_MEASURE;
            end else if (strobe) begin
               if (cnt_q == ({8'd0, settle_q} - 16'd1)) begin
                  cnt_d   = '0;
                  state_d = ST_MEASURE;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_MEASURE: begin
            if (strobe) begin
               acc_en = 1'b1;
               if (cnt_q == ((16'd1 << dwell_q) - 16'd1)) begin
                  cnt_d   = '0;
                  vld_d   = 1'b1;
                  ch_d    = sel_q;
                  val_d   = avg;
                  peak_d  = peak;
                  bank_d[int'(sel_q)*RSSI_W +: RSSI_W] = avg;
                  state_d = ST_PUBLISH;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         ST_PUBLISH: begin
            clr = 1'b1;
            if (nxt_sel <= sel_q) begin
               if (enable) begin
                  mask_d = rssi_mask;
                  if (rssi_mask == '0) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     sel_d   = first_sel;
                     cont_d  = 1'b1;
                     state_d = ST_SETTLE;
                  end
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (cont_q && !enable) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               sel_d   = nxt_sel;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         settle_q <= '0;
         dwell_q  <= '0;
         sel_q    <= '0;
         cont_q   <= 1'b0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
         ch_q     <= '0;
         val_q    <= '0;
         bank_q   <= '0;
         done_q   <= 1'b0;
         peak_q   <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         settle_q <= settle_d;
         dwell_q  <= dwell_d;
         sel_q    <= sel_d;
         cont_q   <= cont_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
         ch_q     <= ch_d;
         val_q    <= val_d;
         bank_q   <= bank_d;
         done_q   <= done_d;
         peak_q   <= peak_d;
      end
   end

   assign sel       = sel_q;
   assign busy      = (state_q != ST_IDLE);
   assign rssi_vld  = vld_q;
   assign rssi_ch   = ch_q;
   assign rssi_val  = val_q;
   assign rssi_bank = bank_q;
   assign done      = done_q;
   assign rssi_peak = peak_q;

endmodule

// File: tb/tb_wca_rssi_scheduler.sv
// Directed bench for wca_rssi_scheduler (NCH=4). Peak checks follow
// WCA_RSSI_PEAK_EN.
module tb_wca_rssi_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable, start;
   logic [3:0]  rssi_mask;
   logic [7:0]  settle;
   logic [3:0]  dwell_log2;
   logic        strobe;
   logic [47:0] adc;
   logic [1:0]  sel;
   logic        busy, rssi_vld, done;
   logic [1:0]  rssi_ch;
   logic [7:0]  rssi_val, rssi_peak;
   logic [31:0] rssi_bank;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   int          strb_div = 1;
   int          phase = 0;
   logic [47:0] adc_base = '0;
   bit          alt_en = 1'b0;
   bit          spike_en = 1'b0;
   int          scount = 0;

   int   stb_q[$];
   int   ev_ch[$];
   int   ev_val[$];
   int   ev_cyc[$];
   int   done_cnt = 0;
   int   done_cyc = 0;
   bit   busy_seen = 1'b0;
   int   c0;

   wca_rssi_scheduler #(.NCH(4), .CHW(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .rssi_mask  (rssi_mask),
      .settle     (settle),
      .dwell_log2 (dwell_log2),
      .strobe     (strobe),
      .adc        (adc),
      .sel        (sel),
      .busy       (busy),
      .rssi_vld   (rssi_vld),
      .rssi_ch    (rssi_ch),
      .rssi_val   (rssi_val),
      .rssi_bank  (rssi_bank),
      .done       (done),
      .rssi_peak  (rssi_peak)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Strobe/sample driver; records the edge at which each strobe is sampled.
   initial begin
      strobe = 1'b0;
      adc    = '0;
      forever begin
         @(posedge clock);
         #1;
         if (strb_div == 0) begin
            strobe = 1'b0;
         end else begin
            strobe = (phase == 0);
            phase  = (phase + 1) % strb_div;
         end
         adc = adc_base;
         if (strobe) begin
            stb_q.push_back(cyc + 1);
            if (alt_en)   adc[11:0] = scount[0] ? 12'h800 : 12'h7FF;
            if (spike_en) adc[11:0] = (scount == 2) ? 12'h7FF : 12'h000;
            scount++;
         end
      end
   end

   // Output monitor.
   always @(negedge clock) begin
      if (rssi_vld) begin
         ev_ch.push_back(int'(rssi_ch));
         ev_val.push_back(int'(rssi_val));
         ev_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clr_log();
      ev_ch.delete();
      ev_val.delete();
      ev_cyc.delete();
      stb_q.delete();
      done_cnt  = 0;
      busy_seen = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1;
      start = 1'b1;
      c0    = cyc;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_ev(input string tag, input int n, input int budget);
      int k = 0;
      while (ev_val.size() < n && k < budget) begin
         @(posedge clock);
         k++;
      end
      #1;
      chk(tag, ev_val.size(), n);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(posedge clock);
         k++;
      end
      #1;
      chk(tag, done_cnt, 1);
   endtask

   // Edge index of the n-th strobe sampled at or after edge 'base'.
   function automatic int nth_stb(input int base, input int n);
      int c = 0;
      foreach (stb_q[i]) begin
         if (stb_q[i] >= base) begin
            c++;
            if (c == n) return stb_q[i];
         end
      end
      return -1;
   endfunction

   initial begin
      int e0, e1;
      reset = 1'b1; enable = 1'b0; start = 1'b0;
      rssi_mask = '0; settle = '0; dwell_log2 = '0;
      repeat (3) @(posedge clock);
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      chk("rst_vld", rssi_vld, 0);
      chk("rst_done", done, 0);
      chk("rst_bank", rssi_bank, 0);
      chk("rst_val", rssi_val, 0);
      chk("rst_peak", rssi_peak, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick(2);

      // Single-shot, strobe every cycle.
      rssi_mask = 4'b0101; settle = 8'd2; dwell_log2 = 4'd2;
      adc_base  = {12'h555, 12'hF00, 12'h555, 12'h100};
      strb_div  = 1;
      clr_log();
      pulse_start();
      wait_done("ss_done", 100);
      tick(2);
      chk("ss_nev", ev_val.size(), 2);
      chk("ss_ch0", ev_ch[0], 0);
      chk("ss_val0", ev_val[0], 32'h20);
      chk("ss_cyc0", ev_cyc[0], c0 + 7);
      chk("ss_ch1", ev_ch[1], 2);
      chk("ss_val1", ev_val[1], 32'h1F);
      chk("ss_cyc1", ev_cyc[1], c0 + 14);
      chk("ss_done_cyc", done_cyc, c0 + 15);
      chk("ss_bank", rssi_bank, 32'h001F_0020);
      chk("ss_busy", busy, 0);

      // Single-shot, strobe every 3rd cycle.
      strb_div = 3;
      tick(3);
      clr_log();
      pulse_start();
      wait_done("s3_done", 300);
      tick(2);
      e0 = nth_stb(c0 + 2, 6);
      e1 = nth_stb(e0 + 2, 6);
      chk("s3_nev", ev_val.size(), 2);
      chk("s3_val0", ev_val[0], 32'h20);
      chk("s3_cyc0", ev_cyc[0], e0);
      chk("s3_val1", ev_val[1], 32'h1F);
      chk("s3_cyc1", ev_cyc[1], e1);
      chk("s3_done_cyc", done_cyc, e1 + 1);

      // Continuous scan, then drop enable during ch1 MEASURE.
      strb_div  = 1;
      rssi_mask = 4'hF; settle = 8'd0; dwell_log2 = 4'd1;
      adc_base  = {12'h7FF, 12'hF00, 12'h200, 12'h100};
      tick(3);
      clr_log();
      enable = 1'b1;
      wait_ev("ct_nev5", 5, 200);
      chk("ct_ord0", ev_ch[0], 0);
      chk("ct_ord1", ev_ch[1], 1);
      chk("ct_ord2", ev_ch[2], 2);
      chk("ct_ord3", ev_ch[3], 3);
      chk("ct_ord4", ev_ch[4], 0);
      chk("ct_val3", ev_val[3], 32'hFF);
      tick(1);
      enable = 1'b0;
      wait_done("ct_done", 50);
      tick(3);
      chk("ct_nev", ev_val.size(), 6);
      chk("ct_last_ch", ev_ch[5], 1);
      chk("ct_last_val", ev_val[5], 32'h40);
      chk("ct_done_cyc", done_cyc, ev_cyc[5] + 1);
      chk("ct_busy", busy, 0);
      chk("ct_bank", rssi_bank, 32'hFF1F_4020);

      // Empty mask: start ignored.
      rssi_mask = 4'h0;
      clr_log();
      pulse_start();
      tick(10);
      chk("m0_busy", busy_seen, 0);
      chk("m0_nev", ev_val.size(), 0);
      chk("m0_done", done_cnt, 0);

      // Max magnitude over the longest dwell.
      rssi_mask = 4'b0001; settle = 8'd0; dwell_log2 = 4'd15;
      @(negedge clock);
      scount = 0;
      alt_en = 1'b1;
      clr_log();
      pulse_start();
      wait_done("mx_done", 33000);
      alt_en = 1'b0;
      chk("mx_nev", ev_val.size(), 1);
      chk("mx_val", ev_val[0], 32'hFF);
      chk("mx_ch", ev_ch[0], 0);
`ifdef WCA_RSSI_PEAK_EN
      chk("mx_peak", rssi_peak, 32'hFF);
      // Single spike among zeros.
      dwell_log2 = 4'd2;
      tick(2);
      @(negedge clock);
      scount   = 0;
      spike_en = 1'b1;
      clr_log();
      pulse_start();
      wait_done("sp_done", 50);
      spike_en = 1'b0;
      chk("sp_val", ev_val[0], 32'h3F);
      chk("sp_peak", rssi_peak, 32'hFF);
`else
      chk("mx_peak", rssi_peak, 0);
`endif

      // Asynchronous reset mid-MEASURE, then a fresh scan.
      rssi_mask = 4'b0100; settle = 8'd0; dwell_log2 = 4'd4;
      adc_base  = {12'h555, 12'h100, 12'h555, 12'h100};
      tick(2);
      clr_log();
      pulse_start();
      tick(5);
      chk("ar_pre_sel", sel, 2);
      chk("ar_pre_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_sel", sel, 0);
      chk("ar_bank", rssi_bank, 0);
      chk("ar_val", rssi_val, 0);
      chk("ar_ch", rssi_ch, 0);
      chk("ar_vld", rssi_vld, 0);
      chk("ar_done", done, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick(30);
      chk("ar_nev", ev_val.size(), 0);
      rssi_mask = 4'b0101; settle = 8'd2; dwell_log2 = 4'd2;
      adc_base  = {12'h555, 12'hF00, 12'h555, 12'h100};
      clr_log();
      pulse_start();
      wait_done("ar2_done", 100);
      chk("ar2_val0", ev_val[0], 32'h20);
      chk("ar2_val1", ev_val[1], 32'h1F);
      chk("ar2_bank", rssi_bank, 32'h001F_0020);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
